// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline.
// Holds opcode constants, ALU class encodings, the decoder control bundle
// layout and the default datapath / register-address widths.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 7;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // Decoder control bundle carried from ID into EX (CTRL_W bits).
  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write_enable;
    logic [1:0] alu_op_main;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator.
// Flags when the instruction in EX is a load whose destination (non-x0)
// matches either source field of the valid instruction in ID. Both source
// fields are compared regardless of format; false stalls on I/U are accepted.
// Ports: ex_valid, ex_mem_read, ex_rd_addr (EX side); id_valid,
//        id_rs1_addr, id_rs2_addr (ID side); load_use (result).
module load_use_detect
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  output logic                  load_use
);

  assign load_use = ex_valid & ex_mem_read & (ex_rd_addr != '0) & id_valid &
                    ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Captures the decoder control bundle plus pc/operands/imm/addresses.
// Priority per edge: flush > ex_stall (hold) > load-use bubble > load.
// Ports: clk, rst_n; id_* decoder fields in; flush, ex_stall in;
//        ex_* registered fields out; id_hold (comb stall to PC/IF-ID);
//        bubble_count (saturating count of load-use bubbles).
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7_b5,
  input  logic                  id_alu_src,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_write_enable,
  input  logic [1:0]            id_alu_op_main,
  input  logic                  flush,
  input  logic                  ex_stall,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [2:0]            ex_funct3,
  output logic                  ex_funct7_b5,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write_enable,
  output logic [1:0]            ex_alu_op_main,
  output logic                  id_hold,
  output logic [CNT_W-1:0]      bubble_count
);

  ctrl_t ctrl_d, ctrl_q;
  logic  load_use;
  logic  load_en;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .ex_valid    (ex_valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .load_use    (load_use)
  );

  assign id_hold = load_use | ex_stall;
  assign load_en = ~flush & ~ex_stall & ~load_use;

  // Control is zeroed for non-instructions; mem_to_reg is gated by mem_read
  // so an undefined decoder value on store/branch never reaches EX.
  always_comb begin
    ctrl_d = '0;
    if (id_valid) begin
      ctrl_d.alu_src          = id_alu_src;
      ctrl_d.mem_to_reg       = id_mem_to_reg & id_mem_read;
      ctrl_d.mem_read         = id_mem_read;
      ctrl_d.mem_write        = id_mem_write;
      ctrl_d.reg_write_enable = id_reg_write_enable;
      ctrl_d.alu_op_main      = id_alu_op_main;
    end
  end

  // Valid + control: flush squashes even under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ctrl_q   <= '0;
    end else if (flush || (!ex_stall && load_use)) begin
      ex_valid <= 1'b0;
      ctrl_q   <= '0;
    end else if (!ex_stall) begin
      ex_valid <= id_valid;
      ctrl_q   <= ctrl_d;
    end
  end

  // Datapath/address fields only move on a real load; they keep stale
  // values across bubbles and flushes (ex_valid qualifies them).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
    end else if (load_en) begin
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_funct3    <= id_funct3;
      ex_funct7_b5 <= id_funct7_b5;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_count <= '0;
    else if (!flush && !ex_stall && load_use && (bubble_count != {CNT_W{1'b1}}))
      bubble_count <= bubble_count + 1'b1;
  end

  assign ex_alu_src          = ctrl_q.alu_src;
  assign ex_mem_to_reg       = ctrl_q.mem_to_reg;
  assign ex_mem_read         = ctrl_q.mem_read;
  assign ex_mem_write        = ctrl_q.mem_write;
  assign ex_reg_write_enable = ctrl_q.reg_write_enable;
  assign ex_alu_op_main      = ctrl_q.alu_op_main;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// random traffic, all compared against a behavioural model of the EX
// register contents and the saturating bubble counter.
module tb_id_ex_stage;

  localparam int XW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;   // narrow counter so saturation is reachable quickly
  localparam int CMAX = (1 << CW) - 1;
  localparam int BW   = 1 + 4*XW + 3*AW + 3 + 1 + 5 + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [XW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [2:0]    id_funct3;
  logic          id_funct7_b5, id_alu_src, id_mem_to_reg, id_mem_read, id_mem_write;
  logic          id_reg_write_enable;
  logic [1:0]    id_alu_op_main;
  logic          flush, ex_stall;
  logic          ex_valid;
  logic [XW-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [AW-1:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [2:0]    ex_funct3;
  logic          ex_funct7_b5, ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic          ex_reg_write_enable;
  logic [1:0]    ex_alu_op_main;
  logic          id_hold;
  logic [CW-1:0] bubble_count;

  id_ex_stage #(.XLEN(XW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5), .id_alu_src(id_alu_src),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write_enable(id_reg_write_enable), .id_alu_op_main(id_alu_op_main),
    .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write_enable(ex_reg_write_enable), .ex_alu_op_main(ex_alu_op_main),
    .id_hold(id_hold), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Model of what EX should hold.
  logic          m_valid;
  logic [XW-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [AW-1:0] m_rs1a, m_rs2a, m_rda;
  logic [2:0]    m_f3;
  logic          m_f7, m_asrc, m_m2r, m_mr, m_mw, m_rwe;
  logic [1:0]    m_aop;
  int            m_cnt;

  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errs++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
    m_rs1a = 0; m_rs2a = 0; m_rda = 0; m_f3 = 0; m_f7 = 0;
    m_asrc = 0; m_m2r = 0; m_mr = 0; m_mw = 0; m_rwe = 0; m_aop = 0; m_cnt = 0;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_funct3 = 0; id_funct7_b5 = 0;
    id_alu_src = 0; id_mem_to_reg = 0; id_mem_read = 0; id_mem_write = 0;
    id_reg_write_enable = 0; id_alu_op_main = 0; flush = 0; ex_stall = 0;
  endtask

  function automatic logic [BW-1:0] dut_bundle();
    return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
            ex_rd_addr, ex_funct3, ex_funct7_b5, ex_alu_src, ex_mem_to_reg, ex_mem_read,
            ex_mem_write, ex_reg_write_enable, ex_alu_op_main};
  endfunction

  function automatic logic [BW-1:0] model_bundle();
    return {m_valid, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1a, m_rs2a, m_rda, m_f3, m_f7,
            m_asrc, m_m2r, m_mr, m_mw, m_rwe, m_aop};
  endfunction

  // One clock: check the combinational hold, clock, update model, check state.
  task automatic step();
    bit hazard;
    #1;
    hazard = m_valid && m_mr && (m_rda != 0) && id_valid &&
             (m_rda == id_rs1_addr || m_rda == id_rs2_addr);
    check("id_hold", BW'(id_hold), BW'(hazard || ex_stall));
    @(posedge clk);
    if (flush) begin
      m_valid = 0; {m_asrc, m_m2r, m_mr, m_mw, m_rwe, m_aop} = '0;
    end else if (ex_stall) begin
      // EX frozen
    end else if (hazard) begin
      m_valid = 0; {m_asrc, m_m2r, m_mr, m_mw, m_rwe, m_aop} = '0;
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      m_valid = id_valid;
      m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
      m_rs1a = id_rs1_addr; m_rs2a = id_rs2_addr; m_rda = id_rd_addr;
      m_f3 = id_funct3; m_f7 = id_funct7_b5;
      if (id_valid) begin
        m_asrc = id_alu_src; m_m2r = id_mem_to_reg && id_mem_read; m_mr = id_mem_read;
        m_mw = id_mem_write; m_rwe = id_reg_write_enable; m_aop = id_alu_op_main;
      end else begin
        {m_asrc, m_m2r, m_mr, m_mw, m_rwe, m_aop} = '0;
      end
    end
    #1;
    check("ex_bundle", dut_bundle(), model_bundle());
    check("bubble_count", BW'(bubble_count), BW'(m_cnt));
  endtask

  task automatic set_lw(input logic [AW-1:0] rd, input logic [AW-1:0] rs1);
    clear_inputs();
    id_valid = 1; id_rd_addr = rd; id_rs1_addr = rs1; id_mem_read = 1; id_mem_to_reg = 1;
    id_reg_write_enable = 1; id_alu_src = 1; id_funct3 = 3'b010; id_imm = 32'h40;
  endtask

  task automatic set_add(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    clear_inputs();
    id_valid = 1; id_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_reg_write_enable = 1; id_alu_op_main = 2'b10; id_pc = 32'h100;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    #12;
    check("reset_bundle", dut_bundle(), '0);
    check("reset_count", BW'(bubble_count), '0);
    @(posedge clk); #1; rst_n = 1;

    // Normal R-type pass
    set_add(5, 1, 2); id_rs1_data = 32'h11;
    step();
    check("normal_aluop", BW'(ex_alu_op_main), BW'(2'b10));
    check("normal_rs1d", BW'(ex_rs1_data), BW'(32'h11));
    check("normal_rd", BW'(ex_rd_addr), BW'(5));
    check("normal_valid", BW'(ex_valid), BW'(1));

    // Load-use: lw x7 then add using x7 as rs2
    set_lw(7, 1); step();
    set_add(9, 3, 7); step();
    check("lu_valid", BW'(ex_valid), BW'(0));
    check("lu_ctrl", BW'({ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                          ex_reg_write_enable, ex_alu_op_main}), '0);
    check("lu_count", BW'(bubble_count), BW'(1));
    step();
    check("lu_enter_valid", BW'(ex_valid), BW'(1));
    check("lu_enter_rs2", BW'(ex_rs2_addr), BW'(7));

    // lw to x0 must not stall a reader of x0
    set_lw(0, 2); step();
    set_add(4, 0, 3); step();
    check("x0_valid", BW'(ex_valid), BW'(1));
    check("x0_count", BW'(bubble_count), BW'(1));

    // Flush beats stall; no count
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_rs1_addr = 2; id_rs2_addr = 3;
    flush = 1; ex_stall = 1;
    step();
    check("flush_valid", BW'(ex_valid), BW'(0));
    check("flush_mw", BW'(ex_mem_write), BW'(0));
    check("flush_count", BW'(bubble_count), BW'(1));

    // Store with undefined mem_to_reg, then with mem_to_reg=1: both masked
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_mem_to_reg = 1'bx;
    step();
    check("store_m2r_x", BW'(ex_mem_to_reg), BW'(0));
    check("store_mw", BW'(ex_mem_write), BW'(1));
    id_mem_to_reg = 1;
    step();
    check("store_m2r_1", BW'(ex_mem_to_reg), BW'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = AW'($urandom_range(0, 3)); id_rs2_addr = AW'($urandom_range(0, 3));
      id_rd_addr = AW'($urandom_range(0, 3));
      id_funct3 = 3'($urandom); id_funct7_b5 = 1'($urandom);
      id_alu_src = 1'($urandom); id_mem_to_reg = 1'($urandom); id_mem_read = 1'($urandom);
      id_mem_write = 1'($urandom); id_reg_write_enable = 1'($urandom);
      id_alu_op_main = 2'($urandom_range(0, 2));
      flush = ($urandom_range(0, 7) == 0); ex_stall = ($urandom_range(0, 4) == 0);
      step();
    end

    // Mid-stream async reset with a store sitting in EX
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_rs1_addr = 2;
    step();
    check("pre_rst_mw", BW'(ex_mem_write), BW'(1));
    #2; rst_n = 0; #1;
    model_reset();
    check("rst_valid", BW'(ex_valid), BW'(0));
    check("rst_mw", BW'(ex_mem_write), BW'(0));
    check("rst_count", BW'(bubble_count), BW'(0));
    check("rst_hold", BW'(id_hold), BW'(0));
    @(posedge clk); #1; rst_n = 1;

    // Saturation: more load-use pairs than the counter can hold
    for (int i = 0; i < CMAX + 2; i++) begin
      set_lw(7, 0); step();
      set_add(8, 7, 1); step();
    end
    check("sat_count", BW'(bubble_count), BW'(CMAX));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_errs);
    $fatal(1, "timeout");
  end

endmodule
